// File: rtl/pps_ts_framer.sv
// Frames PPS timestamp packets as TAG, SEQ, TS_BYTES payload (padded/truncated), optional checksum (`PPS_TS_FRAMER_CHK_EN).
// Latency: TAG is presented one cycle after upstream valid is seen in IDLE; single registered output stage.
// Backpressure: output holds data/last until accepted; upstream ready only while taking payload or discarding excess.
module pps_ts_framer #(
    parameter int unsigned TS_BYTES = 4,
    parameter logic [7:0]  TAG      = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_s_axis_tdata,
    input  logic       i_s_axis_tkeep,
    input  logic       i_s_axis_tvalid,
    output logic       o_s_axis_tready,
    input  logic       i_s_axis_tlast,
    output logic [7:0] o_m_axis_tdata,
    output logic       o_m_axis_tvalid,
    input  logic       i_m_axis_tready,
    output logic       o_m_axis_tlast,
    output logic       o_err_short,
    output logic       o_err_long,
    output logic       o_busy
);
    localparam int unsigned    CW       = $clog2(TS_BYTES + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(TS_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEQ, S_PAY, S_PAD, S_DISC, S_CHK, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_vld_q, m_vld_d;
    logic [7:0]    m_dat_q, m_dat_d;
    logic          m_last_q, m_last_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          s_rdy;
    logic          slot_free;
`ifdef PPS_TS_FRAMER_CHK_EN
    logic [7:0]    sum_q, sum_d;
`endif

    assign slot_free = !m_vld_q || i_m_axis_tready;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
        m_vld_d     = m_vld_q && !i_m_axis_tready;
        m_dat_d     = m_dat_q;
        m_last_d    = m_last_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        s_rdy       = 1'b0;
`ifdef PPS_TS_FRAMER_CHK_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_s_axis_tvalid && slot_free) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = TAG;
                    m_last_d = 1'b0;
                    state_d  = S_SEQ;
                end
            end
            S_SEQ: begin
                if (slot_free) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = seq_q;
                    m_last_d = 1'b0;
                    cnt_d    = '0;
`ifdef PPS_TS_FRAMER_CHK_EN
                    sum_d    = seq_q;
`endif
                    state_d  = S_PAY;
                end
            end
            S_PAY: begin
                s_rdy = slot_free;
                if (i_s_axis_tvalid && slot_free) begin
                    if (i_s_axis_tkeep) begin
                        m_vld_d  = 1'b1;
                        m_dat_d  = i_s_axis_tdata;
                        m_last_d = 1'b0;
                        cnt_d    = cnt_q + CW'(1);
`ifdef PPS_TS_FRAMER_CHK_EN
                        sum_d    = sum_q + i_s_axis_tdata;
`endif
                        if (cnt_q == LAST_CNT) begin
`ifdef PPS_TS_FRAMER_CHK_EN
                            state_d  = i_s_axis_tlast ? S_CHK : S_DISC;
`else
                            m_last_d = 1'b1;
                            state_d  = i_s_axis_tlast ? S_DONE : S_DISC;
`endif
                            err_long_d = !i_s_axis_tlast;
                        end else if (i_s_axis_tlast) begin
                            err_short_d = 1'b1;
                            state_d     = S_PAD;
                        end
                    end else if (i_s_axis_tlast) begin
                        err_short_d = 1'b1;
                        state_d     = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (slot_free) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = 8'h00;
                    m_last_d = 1'b0;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
`ifdef PPS_TS_FRAMER_CHK_EN
                        state_d  = S_CHK;
`else
                        m_last_d = 1'b1;
                        state_d  = S_DONE;
`endif
                    end
                end
            end
            S_DISC: begin
                // Excess beats are swallowed; the frame tail is emitted only after the packet ends.
                s_rdy = 1'b1;
                if (i_s_axis_tvalid && i_s_axis_tlast) begin
`ifdef PPS_TS_FRAMER_CHK_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PPS_TS_FRAMER_CHK_EN
            S_CHK: begin
                if (slot_free) begin
                    m_vld_d  = 1'b1;
                    m_dat_d  = sum_q;
                    m_last_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // Last byte may already have drained while discarding, so an empty slot also completes.
                if (slot_free) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            seq_q       <= 8'h00;
            cnt_q       <= '0;
            m_vld_q     <= 1'b0;
            m_dat_q     <= 8'h00;
            m_last_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
`ifdef PPS_TS_FRAMER_CHK_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            m_vld_q     <= m_vld_d;
            m_dat_q     <= m_dat_d;
            m_last_q    <= m_last_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
`ifdef PPS_TS_FRAMER_CHK_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign o_s_axis_tready = s_rdy;
    assign o_m_axis_tdata  = m_dat_q;
    assign o_m_axis_tvalid = m_vld_q;
    assign o_m_axis_tlast  = m_last_q;
    assign o_err_short     = err_short_q;
    assign o_err_long      = err_long_q;
    assign o_busy          = (state_q != S_IDLE) || m_vld_q;
endmodule

// File: tb/tb_pps_ts_framer.sv
// Scoreboard bench for pps_ts_framer: directed nominal/short/long, backpressure, seq wrap and mid-frame reset.
module tb_pps_ts_framer;
    localparam int         TS  = 4;
    localparam logic [7:0] TAG = 8'hA5;
`ifdef PPS_TS_FRAMER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_s_axis_tdata;
    logic       i_s_axis_tkeep;
    logic       i_s_axis_tvalid;
    logic       o_s_axis_tready;
    logic       i_s_axis_tlast;
    logic [7:0] o_m_axis_tdata;
    logic       o_m_axis_tvalid;
    logic       i_m_axis_tready;
    logic       o_m_axis_tlast;
    logic       o_err_short;
    logic       o_err_long;
    logic       o_busy;

    pps_ts_framer #(.TS_BYTES(TS), .TAG(TAG)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_s_axis_tdata(i_s_axis_tdata), .i_s_axis_tkeep(i_s_axis_tkeep),
        .i_s_axis_tvalid(i_s_axis_tvalid), .o_s_axis_tready(o_s_axis_tready),
        .i_s_axis_tlast(i_s_axis_tlast),
        .o_m_axis_tdata(o_m_axis_tdata), .o_m_axis_tvalid(o_m_axis_tvalid),
        .i_m_axis_tready(i_m_axis_tready), .o_m_axis_tlast(o_m_axis_tlast),
        .o_err_short(o_err_short), .o_err_long(o_err_long), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic [7:0] dat; logic last; } beat_t;
    beat_t      exp_q[$];
    logic [7:0] pkt_d[$];
    bit         pkt_k[$];
    int         n_checks = 0, n_pass = 0, n_fail = 0;
    int         n_es = 0, n_el = 0, exp_es = 0, exp_el = 0;
    logic [7:0] exp_seq = 8'h00;
    bit         mon_en = 1'b0;
    bit         bp_mode = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] prev_dat;
    logic       prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame for the packet in pkt_d/pkt_k, using the current expected sequence number.
    task automatic push_frame();
        logic [7:0] pay [TS];
        logic [7:0] sum;
        int         cnt = 0;
        bit         fin = 1'b0;
        int         lst = pkt_d.size() - 1;
        for (int j = 0; j < TS; j++) pay[j] = 8'h00;
        for (int i = 0; i <= lst; i++) begin
            if (!fin) begin
                if (pkt_k[i]) begin
                    pay[cnt] = pkt_d[i];
                    cnt++;
                    if (cnt == TS) begin
                        fin = 1'b1;
                        if (i != lst) exp_el++;
                    end else if (i == lst) begin
                        fin = 1'b1;
                        exp_es++;
                    end
                end else if (i == lst) begin
                    fin = 1'b1;
                    exp_es++;
                end
            end
        end
        sum = exp_seq;
        exp_q.push_back('{dat: TAG, last: 1'b0});
        exp_q.push_back('{dat: exp_seq, last: 1'b0});
        for (int j = 0; j < TS; j++) begin
            exp_q.push_back('{dat: pay[j], last: (!CHK && j == TS - 1)});
            sum = sum + pay[j];
        end
        if (CHK) exp_q.push_back('{dat: sum, last: 1'b1});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_accept();
        int t = 0;
        do begin
            @(negedge i_clk);
            t++;
        end while (!o_s_axis_tready && t < 300);
        if (!o_s_axis_tready) check("accept_timeout", o_s_axis_tready, 1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_pkt();
        for (int i = 0; i < pkt_d.size(); i++) begin
            i_s_axis_tdata  = pkt_d[i];
            i_s_axis_tkeep  = pkt_k[i];
            i_s_axis_tlast  = (i == pkt_d.size() - 1);
            i_s_axis_tvalid = 1'b1;
            wait_accept();
        end
        i_s_axis_tvalid = 1'b0;
        i_s_axis_tlast  = 1'b0;
    endtask

    task automatic send_pkt();
        push_frame();
        drive_pkt();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || o_busy) && t < 3000) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain_busy", o_busy, 0);
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic gen_rand(input bit all_keep);
        int len = $urandom_range(1, 7);
        pkt_d.delete();
        pkt_k.delete();
        for (int i = 0; i < len; i++) begin
            pkt_d.push_back(8'($urandom));
            pkt_k.push_back(all_keep || ($urandom_range(0, 9) != 0));
        end
    endtask

    always @(posedge i_clk) begin
        #1;
        i_m_axis_tready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Output monitor: scoreboard pop on each handshake, hold-stability while stalled, error pulse tally.
    always @(negedge i_clk) begin
        beat_t e;
        if (mon_en) begin
            if (hold_prev) begin
                check("hold_tvalid", o_m_axis_tvalid, 1);
                check("hold_tdata", o_m_axis_tdata, prev_dat);
                check("hold_tlast", o_m_axis_tlast, prev_last);
            end
            if (o_m_axis_tvalid && i_m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", o_m_axis_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", o_m_axis_tdata, e.dat);
                    check("m_tlast", o_m_axis_tlast, e.last);
                end
            end
            hold_prev = o_m_axis_tvalid && !i_m_axis_tready;
            prev_dat  = o_m_axis_tdata;
            prev_last = o_m_axis_tlast;
            if (o_err_short) n_es++;
            if (o_err_long)  n_el++;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        i_rst = 1'b1;
        i_s_axis_tdata = 8'h00;
        i_s_axis_tkeep = 1'b0;
        i_s_axis_tvalid = 1'b0;
        i_s_axis_tlast = 1'b0;
        i_m_axis_tready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_m_tvalid", o_m_axis_tvalid, 0);
        check("rst_m_tdata", o_m_axis_tdata, 8'h00);
        check("rst_m_tlast", o_m_axis_tlast, 0);
        check("rst_s_tready", o_s_axis_tready, 0);
        check("rst_err_short", o_err_short, 0);
        check("rst_err_long", o_err_long, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        @(posedge i_clk);
        #1;

        // Nominal frame, with TAG latency checked explicitly.
        pkt_d = '{8'h78, 8'h56, 8'h34, 8'h12};
        pkt_k = '{1, 1, 1, 1};
        push_frame();
        i_s_axis_tdata  = pkt_d[0];
        i_s_axis_tkeep  = 1'b1;
        i_s_axis_tvalid = 1'b1;
        @(negedge i_clk);
        check("lat_pre_tvalid", o_m_axis_tvalid, 0);
        @(posedge i_clk);
        #1;
        check("lat_tvalid", o_m_axis_tvalid, 1);
        check("lat_tag", o_m_axis_tdata, TAG);
        drive_pkt();
        drain();
        check("nom_err_short", n_es, 0);
        check("nom_err_long", n_el, 0);

        // Short packet: padded, single err_short pulse, no upstream ready while padding.
        pkt_d = '{8'hAA, 8'hBB};
        pkt_k = '{1, 1};
        push_frame();
        drive_pkt();
        highs = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_s_axis_tready) highs++;
        end
        check("pad_s_tready_cycles", highs, 0);
        drain();
        check("short_err_short", n_es, 1);
        check("short_err_long", n_el, 0);

        // Long packet: truncated, excess consumed, single err_long pulse.
        pkt_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        pkt_k = '{1, 1, 1, 1, 1, 1};
        send_pkt();
        drain();
        check("long_err_short", n_es, 1);
        check("long_err_long", n_el, 1);

        // Dropped tkeep=0 beats, including one carrying tlast.
        pkt_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        pkt_k = '{1, 0, 1, 0};
        send_pkt();
        drain();
        check("keep_err_short", n_es, 2);

        // Random downstream backpressure over random packets.
        bp_mode = 1'b1;
        for (int f = 0; f < 50; f++) begin
            gen_rand(1'b0);
            send_pkt();
        end
        drain();
        bp_mode = 1'b0;
        check("bp_err_short", n_es, exp_es);
        check("bp_err_long", n_el, exp_el);

        // Sequence number wrap.
        for (int f = 0; f < 257; f++) begin
            pkt_d = '{8'(f), 8'(f + 1), 8'(f + 2), 8'(f + 3)};
            pkt_k = '{1, 1, 1, 1};
            send_pkt();
        end
        drain();

        // Reset in the middle of the payload.
        mon_en = 1'b0;
        i_s_axis_tdata  = 8'h5A;
        i_s_axis_tkeep  = 1'b1;
        i_s_axis_tlast  = 1'b0;
        i_s_axis_tvalid = 1'b1;
        wait_accept();
        check("pre_rst_tvalid", o_m_axis_tvalid, 1);
        i_rst = 1'b1;
        i_s_axis_tvalid = 1'b0;
        @(posedge i_clk);
        #1;
        check("midrst_m_tvalid", o_m_axis_tvalid, 0);
        check("midrst_busy", o_busy, 0);
        i_rst = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
        mon_en = 1'b1;
        @(posedge i_clk);
        #1;
        pkt_d = '{8'h78, 8'h56, 8'h34, 8'h12};
        pkt_k = '{1, 1, 1, 1};
        send_pkt();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
